fsm_moore_da: RTL and testbench

Moore control FSM for the ASCON associated-data phase, directly downstream of `fsm_moore_init`. It starts on that FSM's `end_initialisation` pulse and accepts associated-data (AD) blocks over a valid/ready handshake. For each block it drives the datapath through one p6 permutation (rounds 6..11) via the shared external round counter, XORs the domain separator after the last block, and then signals end of phase to the plaintext FSM.

---
 rtl/ascon_pkg.sv | 18 +
 rtl/fsm_moore_da.sv | 102 ++++++++++
 tb/tb_fsm_moore_da.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared ASCON control definitions: FSM state encodings and round-counter constants
// used by both the initialisation and associated-data FSMs.
package ascon_pkg;

  localparam logic [3:0] P6_START   = 4'h6;
  localparam logic [3:0] P12_START  = 4'h0;
  localparam logic [3:0] LAST_ROUND = 4'hB;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAd,
    StRoundFirst,
    StRounds,
    StRoundLast,
    StDone
  } da_state_t;

endpackage

// File: rtl/fsm_moore_da.sv
// Moore control FSM for the ASCON associated-data phase: one p6 permutation per
// accepted AD block, domain separation after the last block, then an end-of-phase pulse.
module fsm_moore_da
  import ascon_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       end_initialisation_i,
  input  logic [3:0] round_i,
  input  logic       ad_valid_i,
  input  logic       ad_last_i,
  output logic       ad_ready_o,
  output logic       en_reg_state_o,
  output logic       bypass_xor_begin_o,
  output logic       bypass_xor_end_o,
  output logic       en_cpt_o,
  output logic       init_p6_o,
  output logic       end_associate_o
);

  da_state_t state_q, state_d;
  logic      last_q, last_d;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (end_initialisation_i) state_d = StWaitAd;
      end
      StWaitAd: begin
        if (ad_valid_i) begin
          last_d  = ad_last_i;
          state_d = StRoundFirst;
        end
      end
      StRoundFirst: begin
        state_d = StRounds;
      end
      StRounds: begin
        // Inequality guarantees exit even if the shared counter skips a value.
        if (round_i >= LAST_ROUND - 4'd1) state_d = StRoundLast;
      end
      StRoundLast: begin
        state_d = last_q ? StDone : StWaitAd;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ad_ready_o         = 1'b0;
    en_reg_state_o     = 1'b0;
    bypass_xor_begin_o = 1'b1;
    bypass_xor_end_o   = 1'b1;
    en_cpt_o           = 1'b0;
    init_p6_o          = 1'b0;
    end_associate_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StWaitAd: begin
        ad_ready_o = 1'b1;
        init_p6_o  = 1'b1;
      end
      StRoundFirst: begin
        en_reg_state_o     = 1'b1;
        en_cpt_o           = 1'b1;
        bypass_xor_begin_o = 1'b0;
      end
      StRounds: begin
        en_reg_state_o = 1'b1;
        en_cpt_o       = 1'b1;
      end
      StRoundLast: begin
        en_reg_state_o   = 1'b1;
        bypass_xor_end_o = ~last_q;
      end
      StDone: begin
        end_associate_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_moore_da.sv
// Directed self-checking bench for fsm_moore_da with a behavioural shared round counter.
module tb_fsm_moore_da;
  import ascon_pkg::*;

  logic       clock;
  logic       resetb;
  logic       end_init;
  logic [3:0] round;
  logic       ad_valid;
  logic       ad_last;
  logic       ad_ready;
  logic       en_reg;
  logic       bxb;
  logic       bxe;
  logic       en_cpt;
  logic       init_p6;
  logic       end_assoc;

  int n_assert = 0;
  int n_fail   = 0;

  // Output vector {ready, en_reg, bxb, bxe, en_cpt, init_p6, end_assoc}
  localparam logic [6:0] O_IDLE = 7'b0011000;
  localparam logic [6:0] O_WAIT = 7'b1011010;
  localparam logic [6:0] O_RF   = 7'b0101100;
  localparam logic [6:0] O_RN   = 7'b0111100;
  localparam logic [6:0] O_RLN  = 7'b0111000;
  localparam logic [6:0] O_RLL  = 7'b0110000;
  localparam logic [6:0] O_DONE = 7'b0011001;

  fsm_moore_da dut (
    .clock_i              (clock),
    .resetb_i             (resetb),
    .end_initialisation_i (end_init),
    .round_i              (round),
    .ad_valid_i           (ad_valid),
    .ad_last_i            (ad_last),
    .ad_ready_o           (ad_ready),
    .en_reg_state_o       (en_reg),
    .bypass_xor_begin_o   (bxb),
    .bypass_xor_end_o     (bxe),
    .en_cpt_o             (en_cpt),
    .init_p6_o            (init_p6),
    .end_associate_o      (end_assoc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared external round counter
  always @(posedge clock) begin
    if (!resetb)      round <= 4'd0;
    else if (init_p6) round <= 4'd6;
    else if (en_cpt)  round <= round + 4'd1;
  end

  int cyc       = 0;
  int en_cnt    = 0;
  int end_cnt   = 0;
  int acc_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (en_reg) en_cnt <= en_cnt + 1;
    if (end_assoc) end_cnt <= end_cnt + 1;
    if (resetb && ad_ready && ad_valid) acc_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {ad_ready, en_reg, bxb, bxe, en_cpt, init_p6, end_assoc};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered from WAIT_AD; ends in WAIT_AD (non-last) or DONE (last).
  task automatic run_block(input logic last, input logic noise, input logic keep_valid);
    ad_valid = 1'b1;
    ad_last  = last;
    tick();
    chk_out("round_first", O_RF);
    chk_int("round_first_idx", int'(round), 6);
    if (!keep_valid) ad_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (noise && i == 1) end_init = 1'b1;
      tick();
      end_init = 1'b0;
      chk_out("rounds", O_RN);
      chk_int("rounds_idx", int'(round), 7 + i);
    end
    tick();
    chk_out("round_last", last ? O_RLL : O_RLN);
    chk_int("round_last_idx", int'(round), 11);
    if (noise) ad_valid = 1'b1;
    tick();
    if (noise) ad_valid = 1'b0;
    chk_out("after_last", last ? O_DONE : O_WAIT);
  endtask

  int base_en;
  int base_end;
  int base_acc;

  initial begin
    resetb   = 1'b0;
    end_init = 1'b0;
    ad_valid = 1'b0;
    ad_last  = 1'b0;

    // Reset
    tick();
    tick();
    chk_out("reset_out", O_IDLE);
    chk_int("reset_state", int'(dut.state_q), int'(StIdle));
    chk_int("reset_last_q", int'(dut.last_q), 0);
    resetb = 1'b1;
    tick();
    chk_out("idle_hold", O_IDLE);

    // Single last block
    base_en  = en_cnt;
    base_end = end_cnt;
    base_acc = acc_q.size();
    end_init = 1'b1;
    tick();
    end_init = 1'b0;
    chk_out("enter_wait", O_WAIT);
    tick();
    chk_out("wait_1", O_WAIT);
    run_block(1'b1, 1'b0, 1'b0);
    chk_int("single_accept_to_done", cyc - 1 - acc_q[base_acc], 6);
    end_init = 1'b1;  // ignored in DONE
    tick();
    end_init = 1'b0;
    chk_out("done_to_idle", O_IDLE);
    tick();
    chk_out("done_init_ignored", O_IDLE);
    chk_int("single_en_reg_cycles", en_cnt - base_en, 6);
    chk_int("single_end_pulses", end_cnt - base_end, 1);

    // Three back-to-back blocks
    base_en  = en_cnt;
    base_end = end_cnt;
    base_acc = acc_q.size();
    end_init = 1'b1;
    tick();
    end_init = 1'b0;
    chk_out("three_wait", O_WAIT);
    run_block(1'b0, 1'b0, 1'b1);
    run_block(1'b0, 1'b0, 1'b1);
    run_block(1'b1, 1'b0, 1'b0);
    tick();
    chk_out("three_idle", O_IDLE);
    chk_int("three_accepts", acc_q.size() - base_acc, 3);
    chk_int("three_gap_1", acc_q[base_acc + 1] - acc_q[base_acc], 7);
    chk_int("three_gap_2", acc_q[base_acc + 2] - acc_q[base_acc + 1], 7);
    chk_int("three_en_reg_cycles", en_cnt - base_en, 18);
    chk_int("three_end_pulses", end_cnt - base_end, 1);

    // Stall in WAIT_AD, then noisy last block
    base_en  = en_cnt;
    base_acc = acc_q.size();
    end_init = 1'b1;
    tick();
    end_init = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("stall_wait", O_WAIT);
      tick();
    end
    chk_out("stall_wait_end", O_WAIT);
    chk_int("stall_en_reg", en_cnt - base_en, 0);
    run_block(1'b1, 1'b1, 1'b0);
    tick();
    chk_out("noise_idle", O_IDLE);
    chk_int("noise_accepts", acc_q.size() - base_acc, 1);

    // Reset mid-phase at round 8
    base_end = end_cnt;
    end_init = 1'b1;
    tick();
    end_init = 1'b0;
    ad_valid = 1'b1;
    ad_last  = 1'b1;
    tick();
    ad_valid = 1'b0;
    chk_out("mid_rf", O_RF);
    tick();
    tick();
    chk_out("mid_rounds", O_RN);
    chk_int("mid_round_idx", int'(round), 8);
    resetb = 1'b0;
    tick();
    chk_out("mid_reset_idle", O_IDLE);
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_out("mid_stay_idle", O_IDLE);
    chk_int("mid_no_end_pulse", end_cnt - base_end, 0);
    end_init = 1'b1;
    tick();
    end_init = 1'b0;
    chk_out("restart_wait", O_WAIT);
    run_block(1'b1, 1'b0, 1'b0);
    tick();
    chk_out("restart_idle", O_IDLE);
    chk_int("restart_end_pulse", end_cnt - base_end, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
